// File: rtl/orb_frame_pkg.sv
// Shared constants, frame-type encodings and state enum for the frame scheduler.
// Also holds the builder for the status frame layout shared by sync and stats frames.
package orb_frame_pkg;

  localparam logic [7:0]  HDR_SYNC       = 8'hA6;
  localparam logic [7:0]  HDR_STATS      = 8'hA7;
  localparam logic [31:0] TPIU_SYNC_WORD = 32'hFFFFFF7F;

  localparam logic [1:0]  TYPE_TRACE = 2'd0;
  localparam logic [1:0]  TYPE_SYNC  = 2'd1;
  localparam logic [1:0]  TYPE_STATS = 2'd2;

  localparam int TIMER_W = 23;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } sched_state_e;

  // Sync and stats frames differ only in the header byte.
  function automatic logic [127:0] status_frame(
    input logic [7:0]  hdr,
    input logic [15:0] frames_cnt,
    input logic [7:0]  leds,
    input logic [15:0] lost_frames,
    input logic [31:0] total_frames
  );
    return {hdr, frames_cnt, 16'h0000, leds, lost_frames, total_frames, TPIU_SYNC_WORD};
  endfunction

endpackage

// File: rtl/frame_scheduler_sync_timer.sv
// Reloadable down-counter that saturates at zero; zero flags a due sync frame.
// Load has priority over counting so a reload in an enabled cycle is not lost.
module sync_timer #(
  parameter int               WIDTH  = 23,
  parameter logic [WIDTH-1:0] RELOAD = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = RELOAD;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/frame_scheduler.sv
// Picks the next 128-bit frame for the serialiser: sync, then stats, then trace.
// Holds each offer until taken; pops the trace buffer in the selection cycle only.
module frame_scheduler
  import orb_frame_pkg::*;
#(
  parameter int SYNC_INTERVAL = 8388607,
  parameter int MAX_BURST     = 64,
  parameter int BUFFLENLOG2   = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Enable,
  input  logic [127:0]           Frame,
  input  logic                   FrameReady,
  output logic                   FrameNext,
  input  logic [BUFFLENLOG2-1:0] FramesCnt,
  input  logic                   StatsReq,
  input  logic [7:0]             Leds,
  input  logic [15:0]            LostFrames,
  input  logic [31:0]            TotalFrames,
  output logic [127:0]           OutFrame,
  output logic                   OutValid,
  input  logic                   OutTaken,
  output logic [1:0]             OutType
);

  localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  sched_state_e       state_q, state_d;
  logic [127:0]       out_frame_q, out_frame_d;
  logic [1:0]         out_type_q, out_type_d;
  logic               out_valid_q, out_valid_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               stats_pend_q, stats_pend_d;

  logic               timer_zero;
  logic               sync_pending;
  logic               sel_sync;
  logic               pop;
  logic [15:0]        frames_cnt_ext;

  assign frames_cnt_ext = 16'(FramesCnt);
  assign sync_pending   = timer_zero || (burst_q == BURST_MAX);

  sync_timer #(
    .WIDTH  (TIMER_W),
    .RELOAD (TIMER_W'(SYNC_INTERVAL))
  ) u_sync_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (sel_sync),
    .enable (Enable),
    .zero   (timer_zero)
  );

  always_comb begin
    state_d      = state_q;
    out_frame_d  = out_frame_q;
    out_type_d   = out_type_q;
    out_valid_d  = out_valid_q;
    burst_d      = burst_q;
    stats_pend_d = stats_pend_q;
    sel_sync     = 1'b0;
    pop          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          if (sync_pending) begin
            sel_sync    = 1'b1;
            out_frame_d = status_frame(HDR_SYNC, frames_cnt_ext, Leds, LostFrames, TotalFrames);
            out_type_d  = TYPE_SYNC;
            out_valid_d = 1'b1;
            burst_d     = '0;
            state_d     = ST_OFFER;
          end else if (stats_pend_q) begin
            out_frame_d  = status_frame(HDR_STATS, frames_cnt_ext, Leds, LostFrames, TotalFrames);
            out_type_d   = TYPE_STATS;
            out_valid_d  = 1'b1;
            stats_pend_d = 1'b0;
            state_d      = ST_OFFER;
          end else if (FrameReady) begin
            pop         = 1'b1;
            out_frame_d = Frame;
            out_type_d  = TYPE_TRACE;
            out_valid_d = 1'b1;
            if (burst_q != BURST_MAX) begin
              burst_d = burst_q + 1'b1;
            end
            state_d = ST_OFFER;
          end
        end
      end
      ST_OFFER: begin
        // An offer is never withdrawn, even if Enable has dropped meanwhile.
        if (OutTaken) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new request arriving as the previous one is serviced must not be lost.
    if (StatsReq) begin
      stats_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      out_frame_q  <= '0;
      out_type_q   <= TYPE_TRACE;
      out_valid_q  <= 1'b0;
      burst_q      <= '0;
      stats_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_frame_q  <= out_frame_d;
      out_type_q   <= out_type_d;
      out_valid_q  <= out_valid_d;
      burst_q      <= burst_d;
      stats_pend_q <= stats_pend_d;
    end
  end

  // During reset the timer reads zero, so sync priority keeps the pop strobe low.
  assign FrameNext = pop;
  assign OutFrame  = out_frame_q;
  assign OutType   = out_type_q;
  assign OutValid  = out_valid_q;

endmodule
